// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and baud divisor helper.
// Imported by both the transmitter and the receive-side detector.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-source side of the UART transmitter.
// Handshake: tx_start acts as valid and ~tx_busy as ready; a byte is taken on the edge where both
// hold, plus the frame-end edge (tx_done) so a held tx_start chains frames with no idle bit time.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_start, output tx_data, input tx, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-time counter: tick on the last clock of each bit, wraps to 0 by itself.
// clr holds the count at 0 so the first bit after an idle period gets a full bit time.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits on an idle-high line.
// tx is registered and driven from the next state, so it changes on the same edge as the state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_if.slave    bus,
  output uart_state_e dbg_state
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 tick;

  uart_baud_tick #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      ST_IDLE:  accept = bus.tx_start;
      ST_START: if (tick) begin
        state_d = ST_DATA;
        bit_d   = '0;
      end
      ST_DATA: if (tick) begin
        if (bit_q == LAST_DATA) begin
          state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          bit_d   = '0;
        end else begin
          bit_d   = bit_q + BW'(1);
          shift_d = shift_q >> 1;
        end
      end
      ST_PARITY: if (tick) state_d = ST_STOP;
      ST_STOP: if (tick) begin
        if (bit_q == LAST_STOP) begin
          // Frame end is also an accept point so back-to-back frames have no idle gap.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          accept  = bus.tx_start;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      state_d = ST_START;
      shift_d = bus.tx_data;
      bit_d   = '0;
      par_d   = (PARITY == PARITY_ODD) ? ~^bus.tx_data : ^bus.tx_data;
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = (state_q != ST_IDLE);
  assign bus.tx_done = done_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five frame formats driven in parallel from one stimulus stream and
// checked every cycle against a bit-position model of the serial frame.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int NCFG = 5;
  localparam int BAUD = 100;
  localparam int DB [NCFG] = '{8, 8, 8, 7, 5};
  localparam int PAR[NCFG] = '{0, 2, 1, 0, 2};
  localparam int SB [NCFG] = '{1, 1, 1, 2, 1};
  localparam int CF [NCFG] = '{1000, 1000, 1000, 1000, 200};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_r = 1'b0;
  logic [8:0]      data_r = '0;
  logic [NCFG-1:0] tx_w, busy_w, done_w;
  uart_state_e     st_w [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    uart_tx_if #(.DATA_BITS(DB[g])) bus ();
    assign bus.tx_start = start_r;
    assign bus.tx_data  = data_r[DB[g]-1:0];
    assign tx_w[g]      = bus.tx;
    assign busy_w[g]    = bus.tx_busy;
    assign done_w[g]    = bus.tx_done;
    uart_tx #(
      .CLK_FREQ (CF[g]),
      .BAUD     (BAUD),
      .DATA_BITS(DB[g]),
      .PARITY   (PAR[g]),
      .STOP_BITS(SB[g])
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .dbg_state(st_w[g])
    );
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: a frame is a vector of line levels, one per bit time, indexed by cycles since accept.
  bit          act  [NCFG];
  int          pos  [NCFG];
  logic [15:0] fb   [NCFG];
  bit          edone[NCFG];

  int          done_at[NCFG];
  int          ndone  [NCFG];
  logic [15:0] samp   [NCFG];

  function automatic int cpb(input int k);
    return CF[k] / BAUD;
  endfunction

  function automatic int nbits(input int k);
    return 1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + SB[k];
  endfunction

  function automatic logic [15:0] frame_bits(input int k, input logic [8:0] d);
    logic [15:0] b;
    int ones;
    b = '1;
    b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB[k]; i++) begin
      b[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (PAR[k] == 2) b[1+DB[k]] = (ones % 2 == 1);
    if (PAR[k] == 1) b[1+DB[k]] = (ones % 2 == 0);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  task automatic model_edge();
    for (int k = 0; k < NCFG; k++) begin
      edone[k] = 1'b0;
      if (rst) begin
        act[k] = 1'b0;
      end else begin
        if (act[k]) begin
          pos[k]++;
          if (pos[k] == nbits(k) * cpb(k)) begin
            act[k]   = 1'b0;
            edone[k] = 1'b1;
          end
        end
        if (!act[k] && start_r) begin
          act[k] = 1'b1;
          pos[k] = 0;
          fb[k]  = frame_bits(k, data_r);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic exp_tx;
    for (int k = 0; k < NCFG; k++) begin
      exp_tx = act[k] ? fb[k][pos[k] / cpb(k)] : 1'b1;
      check($sformatf("tx[%0d]", k), 32'(tx_w[k]), 32'(exp_tx));
      check($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(act[k]));
      check($sformatf("done[%0d]", k), 32'(done_w[k]), 32'(edone[k]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic record(input int e);
    int c;
    for (int k = 0; k < NCFG; k++) begin
      c = cpb(k);
      if ((e % c) == c / 2 && (e / c) < 16) samp[k][e/c] = tx_w[k];
      if (done_w[k]) begin
        ndone[k]++;
        if (done_at[k] < 0) done_at[k] = e;
      end
    end
  endtask

  function automatic bit all_done_f();
    for (int k = 0; k < NCFG; k++) if (done_at[k] < 0) return 1'b0;
    return 1'b1;
  endfunction

  // Send one byte to every config; optionally re-pulse tx_start with 0x1FF at elapsed inj_at.
  task automatic run_frame(input logic [8:0] d, input int inj_at);
    int e;
    bit fin;
    for (int k = 0; k < NCFG; k++) begin
      done_at[k] = -1;
      ndone[k]   = 0;
      samp[k]    = '1;
    end
    data_r  = d;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    e = 0;
    record(e);
    fin = all_done_f();
    while (!fin && e < 300) begin
      if (e == inj_at) begin
        data_r  = 9'h1FF;
        start_r = 1'b1;
      end else begin
        start_r = 1'b0;
      end
      step();
      e++;
      record(e);
      fin = all_done_f();
    end
    start_r = 1'b0;
    if (!fin) fail_now("frame_timeout");
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_w != '0 && n < budget) begin
      step();
      n++;
    end
    if (busy_w != '0) fail_now("idle_timeout");
  endtask

  initial begin
    int e, e1, e2, nd;
    logic [9:0] sb;

    // Reset held three cycles, then again in the middle of idle.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", 32'(tx_w), 32'({NCFG{1'b1}}));
      check("rst_busy", 32'(busy_w), 32'(0));
      check("rst_state", 32'(st_w[0]), 32'(ST_IDLE));
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_rst_tx", 32'(tx_w[0]), 32'(1));
      check("idle_rst_done", 32'(done_w), 32'(0));
    end
    rst = 1'b0;
    step();

    // 8N1 0xA5 plus the other formats.
    run_frame(9'h0A5, -1);
    check("a5_bits_k0", 32'(samp[0][9:0]), 32'(10'b1101001010));
    check("a5_len_k0", done_at[0], 100);
    check("a5_len_k1", done_at[1], 110);
    check("a5_len_k2", done_at[2], 110);
    check("a5_len_k3", done_at[3], 100);
    check("a5_len_k4", done_at[4], 16);
    wait_idle(50);

    // Parity on 0x07.
    run_frame(9'h007, -1);
    check("par_even_07", 32'(samp[1][9]), 32'(1));
    check("par_odd_07", 32'(samp[2][9]), 32'(0));
    check("k3_bits_07", 32'(samp[3][9:0]), 32'(10'b1100001110));
    check("k4_bits_07", 32'(samp[4][7:0]), 32'(8'b11001110));
    wait_idle(50);

    // Start request during a frame is ignored.
    run_frame(9'h03C, 30);
    check("ign_bits_k0", 32'(samp[0][9:0]), 32'(10'b1001111000));
    check("ign_ndone_k0", ndone[0], 1);
    wait_idle(300);

    // Back-to-back with tx_start held high.
    data_r  = 9'h055;
    start_r = 1'b1;
    step();
    data_r = 9'h00F;
    e  = 0;
    e1 = -1;
    while (e1 < 0 && e < 150) begin
      step();
      e++;
      if (e == 99) check("b2b_last_stop", 32'(tx_w[0]), 32'(1));
      if (done_w[0]) e1 = e;
    end
    start_r = 1'b0;
    check("b2b_first_done", e1, 100);
    check("b2b_no_gap", 32'(tx_w[0]), 32'(0));
    sb = '1;
    e2 = -1;
    while (e2 < 0 && e < 300) begin
      step();
      e++;
      if (((e - e1) % 10) == 5 && (e - e1) < 100) sb[(e-e1)/10] = tx_w[0];
      if (done_w[0]) e2 = e;
    end
    if (e2 < 0) fail_now("b2b_second_done");
    check("b2b_spacing", e2 - e1, 100);
    check("b2b_bits_0f", 32'(sb), 32'(10'b1000011110));
    wait_idle(400);

    // Reset in the middle of a frame.
    data_r  = 9'h096;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    for (int i = 1; i <= 45; i++) step();
    rst = 1'b1;
    step();
    check("midrst_tx", 32'(tx_w[0]), 32'(1));
    check("midrst_busy", 32'(busy_w[0]), 32'(0));
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (done_w[0]) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_frame(9'h03A, -1);
    check("post_rst_bits", 32'(samp[0][9:0]), 32'(10'b1001110100));
    check("post_rst_len", done_at[0], 100);
    wait_idle(50);

    // Randomized requests, overlapping pulses and occasional resets.
    for (int it = 0; it < 40; it++) begin
      int gap, hold;
      gap  = $urandom_range(0, 120);
      hold = $urandom_range(1, 3);
      for (int i = 0; i < gap; i++) step();
      data_r  = 9'($urandom);
      start_r = 1'b1;
      for (int i = 0; i < hold; i++) step();
      start_r = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(0, 60)); i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    wait_idle(400);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
